// File: rtl/badminton_rally_ctrl.sv
// Rally sequencer: serve/flight/point/game-over decisions once per frame tick.
// Ports: Clk, Reset, frame_clk, hit_l/hit_r keys, player boxes p1/p2, shuttle
//   position in; ball_hold, ball_launch, ball_vx/vy, server, scores,
//   game_over, state_dbg out.
module badminton_rally_ctrl #(
    parameter int          SCORE_MAX   = 21,
    parameter int          NET_X       = 320,
    parameter int          FLOOR_Y     = 440,
    parameter int          X_LIMIT     = 639,
    parameter int          HOLD_FRAMES = 60,
    parameter int          HIT_VX      = 4,
    parameter logic [9:0]  HIT_VY      = 10'h3FA
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       hit_l,
    input  logic       hit_r,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_x,
    input  logic [9:0] p2_y,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       ball_hold,
    output logic       ball_launch,
    output logic [9:0] ball_vx,
    output logic [9:0] ball_vy,
    output logic       server,
    output logic [4:0] score_l,
    output logic [4:0] score_r,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        SERVE     = 3'd0,
        FLIGHT    = 3'd1,
        POINT     = 3'd2,
        GAME_OVER = 3'd3
    } state_t;

    localparam logic [9:0] VX_L      = 10'(HIT_VX);
    localparam logic [9:0] VX_R      = ~VX_L + 10'd1;
    localparam logic [4:0] SMAX      = 5'(SCORE_MAX);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [9:0] NET       = 10'(NET_X);
    localparam logic [9:0] FLOOR     = 10'(FLOOR_Y);
    localparam logic [9:0] XLIM      = 10'(X_LIMIT);

    state_t     state;
    logic       last_hitter;
    logic       winner;
    logic [7:0] cnt;
    logic       fs1, fs2, fs3;
    logic       tick;

    // Two sync flops plus one delay flop; tick marks a sampled rising edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fs1 <= 1'b0;
            fs2 <= 1'b0;
            fs3 <= 1'b0;
        end else begin
            fs1 <= frame_clk;
            fs2 <= fs1;
            fs3 <= fs2;
        end
    end

    assign tick = fs2 & ~fs3;

    // Zero-extended to 11 bits so box edges near 1023 cannot wrap.
    logic [10:0] bx, by;
    logic        in_l, in_r;
    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign in_l = ({1'b0, p1_x} <= bx) && (bx <= {1'b0, p1_x} + 11'd40)
               && ({1'b0, p1_y} <= by) && (by <= {1'b0, p1_y} + 11'd80);
    assign in_r = ({1'b0, p2_x} <= bx) && (bx <= {1'b0, p2_x} + 11'd40)
               && ({1'b0, p2_y} <= by) && (by <= {1'b0, p2_y} + 11'd80);

    logic land, out_b, fwin, hit_ok_l, hit_ok_r, srv_key;
    logic [4:0] win_score;
    assign land     = ball_y >= FLOOR;
    assign out_b    = (ball_x == 10'd0) || (ball_x >= XLIM);
    // Landing on the left half scores for the right player.
    assign fwin     = land ? (ball_x < NET) : ~last_hitter;
    assign hit_ok_l = last_hitter && hit_l && in_l;
    assign hit_ok_r = !last_hitter && hit_r && in_r;
    assign srv_key  = server ? hit_r : hit_l;
    assign win_score = winner ? score_r : score_l;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= SERVE;
            server      <= 1'b0;
            last_hitter <= 1'b1;
            winner      <= 1'b0;
            cnt         <= '0;
            score_l     <= '0;
            score_r     <= '0;
            ball_hold   <= 1'b1;
            ball_launch <= 1'b0;
            ball_vx     <= '0;
            ball_vy     <= '0;
            game_over   <= 1'b0;
        end else begin
            ball_launch <= 1'b0;
            case (state)
                SERVE: begin
                    if (tick && srv_key) begin
                        ball_launch <= 1'b1;
                        ball_vx     <= server ? VX_R : VX_L;
                        ball_vy     <= HIT_VY;
                        last_hitter <= server;
                        ball_hold   <= 1'b0;
                        state       <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (tick) begin
                        if (land || out_b) begin
                            winner    <= fwin;
                            server    <= fwin;
                            cnt       <= '0;
                            ball_hold <= 1'b1;
                            state     <= POINT;
                            if (fwin) begin
                                if (score_r < SMAX) score_r <= score_r + 5'd1;
                            end else begin
                                if (score_l < SMAX) score_l <= score_l + 5'd1;
                            end
                        end else if (hit_ok_l || hit_ok_r) begin
                            ball_launch <= 1'b1;
                            ball_vx     <= hit_ok_r ? VX_R : VX_L;
                            ball_vy     <= HIT_VY;
                            last_hitter <= hit_ok_r;
                        end
                    end
                end
                POINT: begin
                    if (tick) begin
                        if (cnt == HOLD_LAST) begin
                            if (win_score == SMAX) begin
                                game_over <= 1'b1;
                                state     <= GAME_OVER;
                            end else begin
                                state <= SERVE;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                GAME_OVER: begin
                    if (tick && (hit_l || hit_r)) begin
                        score_l     <= '0;
                        score_r     <= '0;
                        server      <= 1'b0;
                        last_hitter <= 1'b1;
                        game_over   <= 1'b0;
                        state       <= SERVE;
                    end
                end
                default: begin
                    ball_hold <= 1'b1;
                    game_over <= 1'b0;
                    state     <= SERVE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
